// File: rtl/sram_phase_sequencer.sv
// sram_phase_sequencer
//
// Owns the single external SRAM port and walks the processing flow:
// UART download -> M3 -> M2 -> M1 (each optional) -> back to VGA display.
// One shared 26-bit saturating counter is the UART end-of-file timer while
// downloading and the hung-stage watchdog while a milestone runs.
//
// Ports
//   CLOCK_50_I, resetn         clock, asynchronous active-low reset
//   UART_RX_I                  raw UART line (idle high), start detector
//   uart_*/m3_*/m2_*/m1_*      SRAM requests from each requester
//   vga_addr                   VGA read address (used in IDLE and ERROR)
//   stage_done[2:0]            milestone done (bit2 M3, bit1 M2, bit0 M1)
//   stage_start[2:0]           one-cycle milestone start pulses
//   uart_rx_initialize/enable  UART receiver control
//   vga_enable                 VGA fetch enable
//   sram_address/write_data/we_n  muxed SRAM request
//   phase                      encoded state (0 IDLE,1 UART,2 M3,3 M2,4 M1,7 ERROR)
//   error                      sticky watchdog trap flag
module sram_phase_sequencer #(
    parameter int         UART_TIMEOUT  = 50_000_000,
    parameter int         STAGE_TIMEOUT = (1 << 26) - 1,
    parameter logic [2:0] STAGE_MASK    = 3'b111
) (
    input  logic        CLOCK_50_I,
    input  logic        resetn,
    input  logic        UART_RX_I,
    input  logic [17:0] uart_addr,
    input  logic [15:0] uart_wdata,
    input  logic        uart_we_n,
    input  logic [17:0] m3_addr,
    input  logic [15:0] m3_wdata,
    input  logic        m3_we_n,
    input  logic [17:0] m2_addr,
    input  logic [15:0] m2_wdata,
    input  logic        m2_we_n,
    input  logic [17:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_we_n,
    input  logic [17:0] vga_addr,
    input  logic [2:0]  stage_done,
    output logic [2:0]  stage_start,
    output logic        uart_rx_initialize,
    output logic        uart_rx_enable,
    output logic        vga_enable,
    output logic [17:0] sram_address,
    output logic [15:0] sram_write_data,
    output logic        sram_we_n,
    output logic [2:0]  phase,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UART  = 3'd1,
        S_M3    = 3'd2,
        S_M2    = 3'd3,
        S_M1    = 3'd4,
        S_ERROR = 3'd7
    } state_t;

    localparam logic [25:0] UART_LAST  = 26'(UART_TIMEOUT - 1);
    localparam logic [25:0] STAGE_LAST = 26'(STAGE_TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [25:0] counter_reg, counter_next, counter_inc;
    logic        rx_meta_reg, rx_s_reg;
    logic [2:0]  done_ok;

    // First enabled stage among the candidate bits, in M3 -> M2 -> M1 order.
    function automatic state_t first_stage(input logic [2:0] bits);
        if (bits[2])      return S_M3;
        else if (bits[1]) return S_M2;
        else if (bits[0]) return S_M1;
        else              return S_IDLE;
    endfunction

    function automatic logic [2:0] start_bits(input state_t s);
        case (s)
            S_M3:    return 3'b100;
            S_M2:    return 3'b010;
            S_M1:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    // A stage's start bit is high only in its first cycle, so masking done
    // with it ignores done in that cycle (handles done held from before).
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_done
            assign done_ok[gi] = stage_done[gi] & ~stage_start[gi];
        end
    endgenerate

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= UART_RX_I;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    always_comb begin
        counter_inc  = (&counter_reg) ? counter_reg : counter_reg + 26'd1;
        state_next   = state_reg;
        counter_next = counter_inc;
        case (state_reg)
            S_IDLE: begin
                counter_next = '0;
                if (!rx_s_reg) state_next = S_UART;
            end
            S_UART: begin
                // A write in the timeout cycle restarts the timer instead of leaving.
                if (!uart_we_n)                   counter_next = '0;
                else if (counter_reg == UART_LAST) state_next = first_stage(STAGE_MASK);
            end
            S_M3: begin
                if (done_ok[2])                     state_next = first_stage(STAGE_MASK & 3'b011);
                else if (counter_reg == STAGE_LAST) state_next = S_ERROR;
            end
            S_M2: begin
                if (done_ok[1])                     state_next = first_stage(STAGE_MASK & 3'b001);
                else if (counter_reg == STAGE_LAST) state_next = S_ERROR;
            end
            S_M1: begin
                if (done_ok[0])                     state_next = S_IDLE;
                else if (counter_reg == STAGE_LAST) state_next = S_ERROR;
            end
            S_ERROR: counter_next = counter_reg;
            default: state_next = S_IDLE;
        endcase
        if (state_next != state_reg) counter_next = '0;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_reg          <= S_IDLE;
            counter_reg        <= '0;
            stage_start        <= 3'b000;
            uart_rx_initialize <= 1'b0;
            uart_rx_enable     <= 1'b0;
            vga_enable         <= 1'b1;
            error              <= 1'b0;
        end else begin
            state_reg          <= state_next;
            counter_reg        <= counter_next;
            stage_start        <= (state_next != state_reg) ? start_bits(state_next) : 3'b000;
            uart_rx_initialize <= (state_reg == S_IDLE) && (state_next == S_UART);
            uart_rx_enable     <= (state_reg == S_UART) && (state_next == S_UART);
            vga_enable         <= (state_next == S_IDLE);
            error              <= error | (state_next == S_ERROR);
        end
    end

    // Combinational from the state register: switches in the state's first
    // cycle and forces we_n high as soon as reset drops the state to IDLE.
    always_comb begin
        sram_address    = vga_addr;
        sram_write_data = 16'd0;
        sram_we_n       = 1'b1;
        case (state_reg)
            S_UART: begin
                sram_address = uart_addr; sram_write_data = uart_wdata; sram_we_n = uart_we_n;
            end
            S_M3: begin
                sram_address = m3_addr; sram_write_data = m3_wdata; sram_we_n = m3_we_n;
            end
            S_M2: begin
                sram_address = m2_addr; sram_write_data = m2_wdata; sram_we_n = m2_we_n;
            end
            S_M1: begin
                sram_address = m1_addr; sram_write_data = m1_wdata; sram_we_n = m1_we_n;
            end
            default: begin
                sram_address = vga_addr; sram_write_data = 16'd0; sram_we_n = 1'b1;
            end
        endcase
    end

    assign phase = state_reg;

endmodule

// File: tb/tb_sram_phase_sequencer.sv
// tb_sram_phase_sequencer
//
// Two sequencers share all stimulus except stage_done: instance A runs all
// stages, instance B runs only M2. A cycle model (phase, cycles-in-phase,
// quiet UART cycles) predicts every output; directed literal checks pin it.
module tb_sram_phase_sequencer;

    localparam int         UART_TO  = 20;
    localparam int         STAGE_TO = 50;
    localparam logic [2:0] MASK_A   = 3'b111;
    localparam logic [2:0] MASK_B   = 3'b010;
    localparam logic [17:0] VGA_A   = 18'h15A5A;

    logic        CLOCK_50_I = 1'b0;
    logic        resetn;
    logic        UART_RX_I;
    logic [17:0] uart_addr, m3_addr, m2_addr, m1_addr, vga_addr;
    logic [15:0] uart_wdata, m3_wdata, m2_wdata, m1_wdata;
    logic        uart_we_n, m3_we_n, m2_we_n, m1_we_n;
    logic [2:0]  done_a, done_b;

    logic [2:0]  st_a, st_b, ph_a, ph_b;
    logic        ini_a, ini_b, en_a, en_b, vga_a, vga_b, err_a, err_b, wn_a, wn_b;
    logic [17:0] addr_a, addr_b;
    logic [15:0] wd_a, wd_b;

    int checks   = 0;
    int failures = 0;

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    sram_phase_sequencer #(.UART_TIMEOUT(UART_TO), .STAGE_TIMEOUT(STAGE_TO), .STAGE_MASK(MASK_A)) dut_a (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .UART_RX_I(UART_RX_I),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we_n(uart_we_n),
        .m3_addr(m3_addr), .m3_wdata(m3_wdata), .m3_we_n(m3_we_n),
        .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_we_n(m2_we_n),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_n(m1_we_n),
        .vga_addr(vga_addr), .stage_done(done_a), .stage_start(st_a),
        .uart_rx_initialize(ini_a), .uart_rx_enable(en_a), .vga_enable(vga_a),
        .sram_address(addr_a), .sram_write_data(wd_a), .sram_we_n(wn_a),
        .phase(ph_a), .error(err_a));

    sram_phase_sequencer #(.UART_TIMEOUT(UART_TO), .STAGE_TIMEOUT(STAGE_TO), .STAGE_MASK(MASK_B)) dut_b (
        .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .UART_RX_I(UART_RX_I),
        .uart_addr(uart_addr), .uart_wdata(uart_wdata), .uart_we_n(uart_we_n),
        .m3_addr(m3_addr), .m3_wdata(m3_wdata), .m3_we_n(m3_we_n),
        .m2_addr(m2_addr), .m2_wdata(m2_wdata), .m2_we_n(m2_we_n),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we_n(m1_we_n),
        .vga_addr(vga_addr), .stage_done(done_b), .stage_start(st_b),
        .uart_rx_initialize(ini_b), .uart_rx_enable(en_b), .vga_enable(vga_b),
        .sram_address(addr_b), .sram_write_data(wd_b), .sram_we_n(wn_b),
        .phase(ph_b), .error(err_b));

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_phase[2] = '{0, 0};
    int   m_age[2]   = '{0, 0};
    int   m_quiet[2] = '{0, 0};
    logic m_s0 = 1'b1, m_s1 = 1'b1, m_rx_now;

    function automatic int next_stage(input logic [2:0] mask, input int from);
        for (int p = from + 1; p <= 4; p++)
            if (mask[4-p]) return p;
        return 0;
    endfunction

    always @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_age[i] = 0; m_quiet[i] = 0;
            end
            m_s0 = 1'b1; m_s1 = 1'b1;
        end else begin
            m_rx_now = m_s1;
            m_s1 = m_s0;
            m_s0 = UART_RX_I;
            for (int i = 0; i < 2; i++) begin
                int nxt;
                logic [2:0] mask, dn;
                mask = (i == 0) ? MASK_A : MASK_B;
                dn   = (i == 0) ? done_a : done_b;
                nxt  = m_phase[i];
                case (m_phase[i])
                    0: if (!m_rx_now) nxt = 1;
                    1: begin
                        if (uart_we_n) begin
                            m_quiet[i]++;
                            if (m_quiet[i] >= UART_TO) nxt = next_stage(mask, 1);
                        end else m_quiet[i] = 0;
                    end
                    2, 3, 4: begin
                        if (m_age[i] >= 1 && dn[4 - m_phase[i]]) nxt = next_stage(mask, m_phase[i]);
                        else if (m_age[i] + 1 >= STAGE_TO)       nxt = 7;
                    end
                    default: nxt = m_phase[i];
                endcase
                if (nxt != m_phase[i]) begin
                    m_phase[i] = nxt; m_age[i] = 0; m_quiet[i] = 0;
                end else m_age[i]++;
            end
        end
    end

    task automatic cmp_inst(input int i, input logic [2:0] ph, input logic [2:0] st,
                            input logic ini, input logic en, input logic vga, input logic err,
                            input logic [17:0] addr, input logic [15:0] wd, input logic wn);
        int p;
        logic [2:0]  e_st;
        logic [17:0] e_addr;
        logic [15:0] e_wd;
        logic        e_wn;
        p    = m_phase[i];
        e_st = (p >= 2 && p <= 4 && m_age[i] == 0) ? (3'b001 << (4 - p)) : 3'b000;
        case (p)
            1:       begin e_addr = uart_addr; e_wd = uart_wdata; e_wn = uart_we_n; end
            2:       begin e_addr = m3_addr;   e_wd = m3_wdata;   e_wn = m3_we_n;   end
            3:       begin e_addr = m2_addr;   e_wd = m2_wdata;   e_wn = m2_we_n;   end
            4:       begin e_addr = m1_addr;   e_wd = m1_wdata;   e_wn = m1_we_n;   end
            default: begin e_addr = vga_addr;  e_wd = 16'd0;      e_wn = 1'b1;      end
        endcase
        chk("m_phase", i, 32'(ph), 32'(p));
        chk("m_start", i, 32'(st), 32'(e_st));
        chk("m_init",  i, 32'(ini), 32'(p == 1 && m_age[i] == 0));
        chk("m_rxen",  i, 32'(en),  32'(p == 1 && m_age[i] >= 1));
        chk("m_vga",   i, 32'(vga), 32'(p == 0));
        chk("m_error", i, 32'(err), 32'(p == 7));
        chk("m_addr",  i, 32'(addr), 32'(e_addr));
        chk("m_wdata", i, 32'(wd),  32'(e_wd));
        chk("m_we_n",  i, 32'(wn),  32'(e_wn));
    endtask

    always @(negedge CLOCK_50_I) begin
        cmp_inst(0, ph_a, st_a, ini_a, en_a, vga_a, err_a, addr_a, wd_a, wn_a);
        cmp_inst(1, ph_b, st_b, ini_b, en_b, vga_b, err_b, addr_b, wd_b, wn_b);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLOCK_50_I);
        #2;
    endtask

    task automatic chk_phase(input string name, input int ea, input int eb);
        chk(name, 0, 32'(ph_a), 32'(ea));
        chk(name, 1, 32'(ph_b), 32'(eb));
    endtask

    initial begin
        resetn = 1'b1; UART_RX_I = 1'b1;
        vga_addr = VGA_A;
        uart_addr = 18'h00100; uart_wdata = 16'hA000; uart_we_n = 1'b1;
        m3_addr = 18'h03333; m3_wdata = 16'h3333; m3_we_n = 1'b1;
        m2_addr = 18'h02222; m2_wdata = 16'h2222; m2_we_n = 1'b1;
        m1_addr = 18'h01111; m1_wdata = 16'h1111; m1_we_n = 1'b1;
        done_a = 3'b000; done_b = 3'b000;
        #1 resetn = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();

        $display("txn reset release phase_a=%0d phase_b=%0d", ph_a, ph_b);
        chk_phase("rst_phase", 0, 0);
        chk("rst_vga", 0, 32'(vga_a), 32'd1);
        chk("rst_start", 0, 32'(st_a), 32'd0);
        chk("rst_error", 0, 32'(err_a), 32'd0);
        chk("rst_rxen", 0, 32'(en_a), 32'd0);
        for (int k = 0; k < 100; k++) begin
            chk("idle_phase", 0, 32'(ph_a), 32'd0);
            chk("idle_addr", 0, 32'(addr_a), 32'(VGA_A));
            chk("idle_we_n", 0, 32'(wn_a), 32'd1);
            tick();
        end
        $display("txn idle 100 cycles addr=%h", addr_a);

        // UART start bit: three edges to reach S_UART
        UART_RX_I = 1'b0;
        tick(); tick(); tick();
        chk_phase("uart_entry", 1, 1);
        chk("uart_init", 0, 32'(ini_a), 32'd1);
        chk("uart_rxen0", 0, 32'(en_a), 32'd0);
        UART_RX_I = 1'b1;
        tick();
        chk("uart_init_off", 0, 32'(ini_a), 32'd0);
        chk("uart_rxen1", 0, 32'(en_a), 32'd1);
        $display("txn uart start init=%0d rxen=%0d", ini_a, en_a);

        for (int s = 0; s < 3; s++) begin
            repeat (9) tick();
            uart_addr = 18'h00100 + 18'(s); uart_wdata = 16'hA000 + 16'(s); uart_we_n = 1'b0;
            #1;
            chk("strobe_we_n", 0, 32'(wn_a), 32'd0);
            chk("strobe_addr", 1, 32'(addr_b), 32'(18'h00100 + 18'(s)));
            chk("strobe_wdata", 0, 32'(wd_a), 32'(16'hA000 + 16'(s)));
            $display("txn uart strobe %0d addr=%h data=%h", s, addr_a, wd_a);
            tick();
            uart_we_n = 1'b1;
        end

        // done held high: every stage lasts exactly two cycles
        done_a = 3'b111; done_b = 3'b111;
        for (int k = 1; k <= UART_TO; k++) begin
            chk_phase("uart_wait", 1, 1);
            tick();
        end
        chk_phase("seq_t21", 2, 3);
        chk("seq_start_a21", 0, 32'(st_a), 32'(3'b100));
        chk("seq_start_b21", 1, 32'(st_b), 32'(3'b010));
        chk("seq_m3_addr", 0, 32'(addr_a), 32'(18'h03333));
        tick();
        chk_phase("seq_t22", 2, 3);
        chk("seq_start_a22", 0, 32'(st_a), 32'd0);
        tick();
        chk_phase("seq_t23", 3, 0);
        chk("seq_start_a23", 0, 32'(st_a), 32'(3'b010));
        chk("seq_vga_b23", 1, 32'(vga_b), 32'd1);
        tick();
        chk_phase("seq_t24", 3, 0);
        tick();
        chk_phase("seq_t25", 4, 0);
        chk("seq_start_a25", 0, 32'(st_a), 32'(3'b001));
        tick();
        chk_phase("seq_t26", 4, 0);
        tick();
        chk_phase("seq_t27", 0, 0);
        chk("seq_vga_a27", 0, 32'(vga_a), 32'd1);
        $display("txn stage sequence done phase_a=%0d phase_b=%0d", ph_a, ph_b);

        // watchdog: A passes M3 then hangs in M2, B hangs in M2
        done_a = 3'b100; done_b = 3'b000;
        repeat (3) tick();
        UART_RX_I = 1'b0;
        tick(); tick(); tick();
        chk_phase("wd_uart", 1, 1);
        UART_RX_I = 1'b1;
        repeat (20) tick();
        chk_phase("wd_u20", 2, 3);
        m2_we_n = 1'b0;
        UART_RX_I = 1'b0;
        repeat (2) tick();
        chk_phase("wd_u22", 3, 3);
        UART_RX_I = 1'b1;
        repeat (47) tick();
        chk_phase("wd_u69", 3, 3);
        chk("wd_we_n_b69", 1, 32'(wn_b), 32'd0);
        tick();
        chk_phase("wd_u70", 3, 7);
        chk("wd_err_b", 1, 32'(err_b), 32'd1);
        chk("wd_we_n_b", 1, 32'(wn_b), 32'd1);
        chk("wd_addr_b", 1, 32'(addr_b), 32'(VGA_A));
        chk("wd_vga_b", 1, 32'(vga_b), 32'd0);
        tick();
        chk_phase("wd_u71", 3, 7);
        tick();
        chk_phase("wd_u72", 7, 7);
        chk("wd_err_a", 0, 32'(err_a), 32'd1);
        done_a = 3'b111; done_b = 3'b111;
        repeat (10) tick();
        chk_phase("wd_hold", 7, 7);
        chk("wd_err_hold", 1, 32'(err_b), 32'd1);
        $display("txn watchdog trap error_a=%0d error_b=%0d", err_a, err_b);

        resetn = 1'b0;
        #1;
        chk_phase("err_rst", 0, 0);
        chk("err_rst_flag", 0, 32'(err_a), 32'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk_phase("err_rst_rel", 0, 0);

        // reset in the middle of an M2 write
        done_a = 3'b100; done_b = 3'b000;
        UART_RX_I = 1'b0;
        tick(); tick(); tick();
        UART_RX_I = 1'b1;
        repeat (22) tick();
        chk_phase("mid_m2", 3, 3);
        chk("mid_we_n_a", 0, 32'(wn_a), 32'd0);
        #1;
        resetn = 1'b0;
        #1;
        chk_phase("mid_rst_phase", 0, 0);
        chk("mid_rst_we_n_a", 0, 32'(wn_a), 32'd1);
        chk("mid_rst_we_n_b", 1, 32'(wn_b), 32'd1);
        chk("mid_rst_addr_a", 0, 32'(addr_a), 32'(VGA_A));
        $display("txn reset mid M2 we_n_a=%0d we_n_b=%0d", wn_a, wn_b);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk_phase("mid_rel_phase", 0, 0);
        chk("mid_rel_vga", 0, 32'(vga_a), 32'd1);
        m2_we_n = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
